// File: rtl/serial_tx_ctrl.sv
// Framing controller for an external parallel-to-serial shifter: start bit,
// 8 data bits MSB first, optional parity bit, stop bit.
module serial_tx_ctrl #(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] inData,
    input  logic       inValid,
    output logic       inReady,
    output logic [7:0] shData,
    output logic       shLoad,
    output logic       shSIn,
    input  logic       shSOut,
    output logic       txOut,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   byte_q, byte_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                load_q, load_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                accept_c;

    // ready_q is high exactly in IDLE and STOP, so accept depends only on flops and inValid
    assign accept_c = inValid && ready_q;

    // Next-state, capture and registered-output decode
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        parity_d  = parity_q;

        if (accept_c) begin
            byte_d   = inData;
            parity_d = (^inData) ^ PARITY_ODD;
        end

        case (state_q)
            IDLE:    if (accept_c) state_d = START;
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(7)) state_d = PARITY_EN ? PARITY : STOP;
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = accept_c ? START : IDLE;
            default: state_d = IDLE;
        endcase

        tx_d    = 1'b1;
        if (state_d == START)  tx_d = 1'b0;
        if (state_d == PARITY) tx_d = parity_d;
        load_d  = (state_d == START);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP);
        ready_d = (state_d == IDLE) || (state_d == STOP);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    // During DATA the line is the shifter's MSB straight through
    assign txOut   = (state_q == DATA) ? shSOut : tx_q;
    assign shData  = byte_q;
    assign shLoad  = load_q;
    assign shSIn   = 1'b0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign inReady = ready_q;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Scoreboard bench for serial_tx_ctrl over three parity configurations,
// each with its own external shifter model and frame-level reference model.
module tb_serial_tx_ctrl;

    typedef struct packed {
        logic       tx;
        logic       busy;
        logic       done;
        logic       ready;
        logic       load;
        logic       chk;
        logic [7:0] data;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit fin [3];

    task automatic check(input string name, input int cfg, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d @%0t: got %h expected %h", name, cfg, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam bit PE   = (g != 0);
        localparam bit PO   = (g == 2);
        localparam int FLEN = PE ? 11 : 10;

        logic       rst;
        logic [7:0] in_data;
        logic       in_valid;
        logic       in_ready;
        logic [7:0] sh_data;
        logic       sh_load;
        logic       sh_sin;
        logic       sh_sout;
        logic       tx_out;
        logic       busy;
        logic       done;
        logic [7:0] shreg;
        logic       in_reset;
        rec_t       exp_q[$];
        rec_t       mon_e;
        int         frame_left;
        logic       accepted;

        serial_tx_ctrl #(.PARITY_EN(PE), .PARITY_ODD(PO)) u_dut (
            .Clock   (clk),
            .Reset   (rst),
            .inData  (in_data),
            .inValid (in_valid),
            .inReady (in_ready),
            .shData  (sh_data),
            .shLoad  (sh_load),
            .shSIn   (sh_sin),
            .shSOut  (sh_sout),
            .txOut   (tx_out),
            .busy    (busy),
            .done    (done)
        );

        // External parallel-load, shift-left register; MSB drives the line
        always @(posedge clk) begin
            if (sh_load) shreg <= sh_data;
            else         shreg <= {shreg[6:0], sh_sin};
        end
        assign sh_sout = shreg[7];

        function automatic rec_t mk(input logic tx, input logic load, input logic ready,
                                    input logic dn, input logic [7:0] b);
            rec_t r;
            r.tx = tx; r.busy = 1'b1; r.done = dn; r.ready = ready;
            r.load = load; r.chk = 1'b1; r.data = b;
            return r;
        endfunction

        // One expected record per line cycle of a whole frame
        function automatic void push_frame(input logic [7:0] b);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, b));
            for (int i = 7; i >= 0; i--) exp_q.push_back(mk(b[i], 1'b0, 1'b0, 1'b0, b));
            if (PE) exp_q.push_back(mk(1'(($countones(b) % 2) != 0) ^ PO, 1'b0, 1'b0, 1'b0, b));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, b));
        endfunction

        // Called right after each posedge: decides acceptance from frame position
        function automatic void model_edge();
            accepted = 1'b0;
            if (in_valid && frame_left <= 1) begin
                push_frame(in_data);
                frame_left = FLEN;
                accepted = 1'b1;
            end else if (frame_left > 0) begin
                frame_left--;
            end
        endfunction

        task automatic cyc(input logic v, input logic [7:0] d);
            @(negedge clk);
            in_valid = v;
            in_data  = d;
            @(posedge clk);
            model_edge();
        endtask

        task automatic send(input logic [7:0] d);
            int n = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            do begin
                @(posedge clk);
                model_edge();
                n++;
            end while (!accepted && n < 40);
            if (!accepted) check("send_timeout", g, 32'(n), 32'(0));
        endtask

        task automatic reset_check(input string nm);
            check(nm, g, {19'b0, tx_out, busy, done, in_ready, sh_load, sh_data},
                         {19'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
        endtask

        always @(negedge clk) begin
            if (!in_reset) begin
                if (exp_q.size() > 0) mon_e = exp_q.pop_front();
                else mon_e = '{tx: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1, load: 1'b0, chk: 1'b0, data: 8'h00};
                check("outputs", g, {26'b0, tx_out, busy, done, in_ready, sh_load, sh_sin},
                                    {26'b0, mon_e.tx, mon_e.busy, mon_e.done, mon_e.ready, mon_e.load, 1'b0});
                if (mon_e.chk) check("shData", g, {24'b0, sh_data}, {24'b0, mon_e.data});
            end
        end

        initial begin
            rst = 1'b1; in_reset = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
            frame_left = 0; accepted = 1'b0;
            #1;
            reset_check("reset_state");
            #21;
            rst = 1'b0; in_reset = 1'b0;
            // first posedge after release accepts 0xA5
            @(posedge clk);
            model_edge();
            repeat (12) cyc(1'b0, 8'h00);
            send(8'h07);
            repeat (13) cyc(1'b0, 8'h00);
            // held valid: back-to-back frames
            send(8'h00);
            send(8'hFF);
            repeat (13) cyc(1'b0, 8'h00);
            // request raised mid-DATA waits for STOP
            send(8'h96);
            repeat (3) cyc(1'b0, 8'h00);
            send(8'h3C);
            repeat (13) cyc(1'b0, 8'h00);
            // asynchronous reset during DATA cycle 4
            send(8'h5A);
            repeat (5) cyc(1'b0, 8'h00);
            #2;
            rst = 1'b1; in_reset = 1'b1;
            #1;
            reset_check("midframe_reset");
            exp_q.delete();
            frame_left = 0;
            in_valid = 1'b1; in_data = 8'h81;
            @(posedge clk);
            #2;
            rst = 1'b0; in_reset = 1'b0;
            @(posedge clk);
            model_edge();
            repeat (12) cyc(1'b0, 8'h00);
            for (int i = 0; i < 400; i++) cyc($urandom_range(0, 3) != 0, 8'($urandom));
            repeat (15) cyc(1'b0, 8'h00);
            fin[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (fin[0] && fin[1] && fin[2]);
            #500000;
        join_any
        disable fork;
        if (!(fin[0] && fin[1] && fin[2])) begin
            checks++;
            errors++;
            $display("FAIL timeout: stimulus did not complete");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_ctrl.md
SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

Interface
REQ-001 Parameter PARITY_EN, default 0: 1 appends a parity bit after the data bits.
REQ-002 Parameter PARITY_ODD, default 0: 0 gives even parity, 1 gives odd parity; only meaningful when PARITY_EN=1.
REQ-003 Clock  input  1  sole clock; all state updates on posedge Clock.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 inData  input  8  byte to transmit; sampled on the accept edge.
REQ-006 inValid  input  1  requester has a byte on inData.
REQ-007 inReady  output  1  controller can accept a byte this cycle.
REQ-008 shData  output  8  parallel load value driven to the external parallel-to-serial shifter.
REQ-009 shLoad  output  1  load strobe to the shifter; registered, glitch-free.
REQ-010 shSIn  output  1  serial fill bit to the shifter; constant 0.
REQ-011 shSOut  input  1  shifter MSB output.
REQ-012 txOut  output  1  framed serial line; idles high.
REQ-013 busy  output  1  frame in progress (any state other than IDLE).
REQ-014 done  output  1  one-cycle pulse during the STOP cycle of each frame.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP, with a 3-bit bit counter bitCnt.
REQ-016 Accept SHALL occur on a posedge where inValid=1 and inReady=1; inReady SHALL be 1 only in IDLE and STOP.
REQ-017 On accept, the byte SHALL be captured into byteReg, shData SHALL equal byteReg thereafter until the next accept, and the parity bit SHALL be computed as (^inData) XOR PARITY_ODD.
REQ-018 IDLE: txOut=1, shLoad=0; on accept go to START, otherwise stay in IDLE.
REQ-019 START: lasts 1 cycle; txOut=0, shLoad=1; then go to DATA with bitCnt=0.
REQ-020 DATA: shLoad=0, txOut=shSOut; bitCnt increments each cycle.
REQ-021 DATA exit: after the cycle with bitCnt=7, go to PARITY if PARITY_EN=1, else to STOP.
REQ-022 Bit order: the shifter captures shData on the edge leaving START, so DATA cycle k SHALL present byteReg[7-k] (MSB first).
REQ-023 PARITY: lasts 1 cycle; txOut=parity bit; then go to STOP.
REQ-024 STOP: lasts 1 cycle; txOut=1, done=1; on accept go to START (back-to-back, no idle gap), else go to IDLE.
REQ-025 Frame length SHALL be 10 cycles (11 with PARITY_EN=1), measured from the first START cycle to the last STOP cycle inclusive.
REQ-026 inData and inValid SHALL be ignored in START, DATA and PARITY; a held inValid SHALL be accepted at the next STOP or IDLE cycle.
REQ-027 txOut, shLoad, busy, done and inReady SHALL be driven from registered state only, with no combinational path from inValid; txOut in DATA is the only exception and is a direct pass of shSOut.

Reset
REQ-028 Reset=1 SHALL immediately, without waiting for a clock edge, force the following: state=IDLE, bitCnt=0, byteReg=0, shData=0, parity bit=0, shLoad=0, txOut=1, busy=0, done=0, inReady=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame, discard the byte, and leave txOut high.
REQ-030 The first accept SHALL be possible on the first posedge after Reset deasserts.

Verification
REQ-031 PARITY_EN=0: accept 0xA5 from IDLE -> txOut = 0,1,0,1,0,0,1,0,1,1; busy high for 10 cycles; done high on cycle 10 only.
REQ-032 PARITY_EN=1, PARITY_ODD=0: send 0xA5 -> parity bit 0 (11-cycle frame). PARITY_ODD=1: send 0xA5 -> parity bit 1. Even parity on 0x07 -> parity bit 1.
REQ-033 inValid held with 0x00 then 0xFF -> the second START immediately follows the first STOP; txOut = 0,0x8,1,0,1x8,1; then IDLE.
REQ-034 Assert inValid with 0x3C during DATA -> inReady=0 and no accept until STOP; 0x3C is transmitted next without loss, and the first byte is not corrupted.
REQ-035 Assert Reset in DATA cycle 4 (between edges) -> txOut=1, busy=0, inReady=1 before the next edge; after release, sending 0x81 gives txOut = 0,1,0,0,0,0,0,0,1,1.
REQ-036 With an external shifter model, shLoad SHALL be high for exactly 1 cycle per frame, and shData SHALL stay stable from START through the end of DATA.
